// File: rtl/gf_mul_seq.sv
// Sequential carry-less (GF(2)) polynomial multiplier, one multiplier bit per clock.
// Latency: start accepted at edge k, op_finish high in the cycle after edge k+DATA_WIDTH.
// Backpressure: none; start is ignored while busy, and op_enable low aborts and keeps product.
module gf_mul_seq #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            op_enable,
    input  logic                            start,
    input  logic [$clog2(DATA_WIDTH):0]     polyn_grade,
    input  logic [DATA_WIDTH-1:0]           a_in,
    input  logic [DATA_WIDTH-1:0]           b_in,
    output logic [2*DATA_WIDTH-1:0]         product,
    output logic                            busy,
    output logic                            op_finish
);

    // Counter width covers bit indices 0..DATA_WIDTH-1.
    // The grade width is one bit wider so that it can hold the value DATA_WIDTH.
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GW = $clog2(DATA_WIDTH) + 1;
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [GW-1:0]           grade_reg;
    logic [CW-1:0]           count;
    logic [PW-1:0]           acc;

    logic [DATA_WIDTH-1:0]   load_mask;
    logic [PW-1:0]           a_ext;
    logic [PW-1:0]           partial;
    logic [PW-1:0]           acc_next;
    logic                    bit_take;
    logic                    last_bit;
    logic                    load;
    logic                    step;
    logic                    finish_d;

    // Coefficients at or above the field degree are dropped when the operands are loaded.
    always_comb begin
        load_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            load_mask[i] = (GW'(i) < polyn_grade);
        end
    end

    // One shift-and-XOR step: the partial product for the current multiplier bit.
    // The grade test is redundant with the load mask. It keeps bits above the
    // latched degree out of the product even if the mask logic is changed later.
    always_comb begin
        a_ext    = {{DATA_WIDTH{1'b0}}, a_reg};
        partial  = a_ext << count;
        bit_take = b_reg[count] && ({1'b0, count} < grade_reg);
        acc_next = bit_take ? (acc ^ partial) : acc;
        last_bit = (count == CW'(DATA_WIDTH - 1));
    end

    // Next-state and control strobes. When op_enable is low, the FSM aborts from any state.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        finish_d = 1'b0;
        if (!op_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = MUL;
                        load    = 1'b1;
                    end
                end
                MUL: begin
                    step = 1'b1;
                    if (last_bit) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operand load, accumulate per bit, and publish the product on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            grade_reg <= '0;
            count     <= '0;
            acc       <= '0;
            product   <= '0;
            op_finish <= 1'b0;
        end else begin
            op_finish <= finish_d;
            if (!op_enable) begin
                count <= '0;
                acc   <= '0;
            end else if (load) begin
                a_reg     <= a_in & load_mask;
                b_reg     <= b_in & load_mask;
                grade_reg <= polyn_grade;
                count     <= '0;
                acc       <= '0;
            end else if (step) begin
                if (last_bit) begin
                    product <= acc_next;
                    acc     <= '0;
                    count   <= '0;
                end else begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                end
            end
        end
    end

    // busy is decoded from the state register only.
    assign busy = (state_q != IDLE);

endmodule

// File: doc/gf_mul_seq.md
GF_MUL_SEQ -- requirements
Module: gf_mul_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 4, field operand width; product bus is 2*DATA_WIDTH bits, matching the downstream reduction block's reduc_in.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op_enable  input  1  synchronous enable; low aborts any operation.
REQ-005 start  input  1  request; sampled only in IDLE with op_enable high.
REQ-006 polyn_grade  input  $clog2(DATA_WIDTH)+1  field degree m, legal range 2..DATA_WIDTH.
REQ-007 a_in  input  DATA_WIDTH  multiplicand polynomial, bit i = coefficient of x^i.
REQ-008 b_in  input  DATA_WIDTH  multiplier polynomial, same encoding.
REQ-009 product  output  2*DATA_WIDTH  unreduced carry-less product a*b over GF(2).
REQ-010 busy  output  1  high while state is MUL or DONE.
REQ-011 op_finish  output  1  one-cycle pulse, product valid.

Function
REQ-012 FSM states: IDLE, MUL, DONE; encoding free.
REQ-013 IDLE -> MUL on an edge with op_enable=1 and start=1: load a_reg, b_reg, and grade_reg from inputs; clear acc and count.
REQ-014 On load, operand bits at index >= polyn_grade are forced to 0 in a_reg and b_reg.
REQ-015 In MUL, each edge: if b_reg[count]=1, acc <= acc XOR (a_reg << count); then count <= count+1.
REQ-016 MUL processes bits 0..DATA_WIDTH-1, exactly DATA_WIDTH edges, independent of polyn_grade.
REQ-017 At the edge processing count=DATA_WIDTH-1: product <= final acc; state -> DONE.
REQ-018 In DONE, op_finish=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
REQ-019 Latency: start accepted at edge k -> op_finish high in the cycle following edge k+DATA_WIDTH; back-to-back start is possible at edge k+DATA_WIDTH+2.
REQ-020 op_finish is registered, not derived combinationally from inputs.
REQ-021 product holds its value from DONE until the next completed operation; it is unchanged by abort.
REQ-022 start asserted in MUL or DONE is ignored; no queuing.
REQ-023 a_in, b_in, and polyn_grade changes after load do not affect the current operation.
REQ-024 All XOR arithmetic is 2*DATA_WIDTH wide; product[2*DATA_WIDTH-1] is always 0.
REQ-025 Product degree is at most 2*polyn_grade-2 because of REQ-014.
REQ-026 op_enable=0 at any edge: state -> IDLE, count/acc cleared, op_finish=0 next cycle; product is kept.
REQ-027 Simultaneous op_enable=0 and start=1: abort/no-load wins.
REQ-028 busy is combinational from state only.

Reset
REQ-029 rst=1 asynchronously forces state=IDLE, count=0, acc=0, a_reg=b_reg=0, product=0, op_finish=0, busy=0.
REQ-030 Reset asserted mid-MUL takes effect immediately, with no op_finish pulse.
REQ-031 After rst deasserts, the first start is accepted on the first edge meeting REQ-013.

Verification (DATA_WIDTH=4)
REQ-032 grade=4, a=4'b1011, b=4'b0110, start pulse -> op_finish exactly 5 cycles after the start edge, product=8'b00111010.
REQ-033 grade=4, a=4'hF, b=4'hF -> product=8'b01010101; op_finish is one cycle wide and busy falls the next cycle.
REQ-034 grade=3, a=4'b1111, b=4'b1000 -> masked b=0, product=8'h00; then grade=3, a=4'b0101, b=4'b0011 -> product=8'b00001111.
REQ-035 op_enable dropped two cycles into MUL -> no op_finish, state IDLE, product retains previous value; a new start then completes correctly.
REQ-036 rst pulse mid-MUL, asynchronous between edges -> all outputs 0 immediately; start held high during MUL -> ignored, single op_finish only.
REQ-037 Random regression against a golden carry-less multiply, then chained into the reduction block with a matching polynomial -> reduced output equals the golden GF(2^m) product.
